// File: rtl/sampler_ctrl_pkg.sv
// Shared types and helpers for the phase-sampled capture controller.
// Holds the FSM state encoding, default sizing and the one-hot phase helper.
package sampler_ctrl_pkg;

  localparam int DEF_PHASES = 4;
  localparam int DEF_LEN_W  = 4;
  localparam int DEF_NREQ   = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Callers size-cast the result down to their own phase count.
  function automatic logic [31:0] onehot(input int unsigned idx);
    onehot = 32'd1 << idx;
  endfunction

endpackage

// File: rtl/sampler_phase_ctrl_arbiter.sv
// Round-robin arbiter that shares the capture datapath between requesters.
// The search starts just after the last granted index; the pointer only moves when en is high.
module rr_arbiter
  import sampler_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt,
  output logic            valid
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] pick_idx;
  int               cand;

  // Walk the requesters in priority order, starting one past the last winner.
  always_comb begin
    gnt      = '0;
    valid    = 1'b0;
    pick_idx = last_idx;
    cand     = 0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = (int'(last_idx) + i) % NREQ;
      if (!valid && req[IDX_W'(cand)]) begin
        valid               = 1'b1;
        gnt[IDX_W'(cand)]   = 1'b1;
        pick_idx            = IDX_W'(cand);
      end
    end
  end

  // The reset pointer sits on the last index, so req[0] wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_idx <= IDX_W'(NREQ - 1);
    end else if (en && valid) begin
      last_idx <= pick_idx;
    end
  end

endmodule

// File: rtl/sampler_phase_ctrl.sv
// Phase-sampled capture controller: grants the datapath to one requester and runs
// a programmable number of one-hot phase rotations, then flushes and signals done.
module sampler_phase_ctrl
  import sampler_ctrl_pkg::*;
#(
  parameter int PHASES = DEF_PHASES,
  parameter int LEN_W  = DEF_LEN_W,
  parameter int NREQ   = DEF_NREQ
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req,
  input  logic [LEN_W-1:0]          cfg_len,
  input  logic                      abort,
  output logic [NREQ-1:0]           gnt,
  output logic                      busy,
  output logic [PHASES-1:0]         phase_en,
  output logic [$clog2(PHASES)-1:0] phase_idx,
  output logic                      capture_valid,
  output logic                      done
);

  localparam int                PIDX_W     = $clog2(PHASES);
  localparam logic [PIDX_W-1:0] LAST_PHASE = PIDX_W'(PHASES - 1);

  state_t            state;
  logic [LEN_W-1:0]  rot_cnt;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  len_eff;
  logic [NREQ-1:0]   arb_gnt;
  logic              arb_valid;
  logic              arb_en;
  logic              rot_end;
  logic              last_rot;
  logic              stop_req;
  logic [PHASES-1:0] next_phase_en;

  assign arb_en = (state == IDLE);

  rr_arbiter #(
    .NREQ (NREQ)
  ) u_arb (
    .clk   (clk),
    .rst   (rst),
    .en    (arb_en),
    .req   (req),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  // A zero length still runs one rotation; the extra bit keeps the compare overflow-safe.
  assign len_eff       = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign rot_end       = (phase_idx == LAST_PHASE);
  assign last_rot      = (({1'b0, rot_cnt} + (LEN_W + 1)'(1)) >= {1'b0, len});
  assign stop_req      = abort || ~|(req & gnt);
  assign next_phase_en = PHASES'(onehot(32'(phase_idx) + 32'd1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      gnt           <= '0;
      busy          <= 1'b0;
      phase_en      <= '0;
      phase_idx     <= '0;
      capture_valid <= 1'b0;
      done          <= 1'b0;
      rot_cnt       <= '0;
      len           <= '0;
    end else begin
      case (state)
        IDLE: begin
          capture_valid <= 1'b0;
          done          <= 1'b0;
          if (arb_valid) begin
            state     <= RUN;
            gnt       <= arb_gnt;
            busy      <= 1'b1;
            phase_idx <= '0;
            phase_en  <= PHASES'(onehot(0));
            len       <= len_eff;
            rot_cnt   <= '0;
          end
        end
        RUN: begin
          // A completed rotation reports capture even when the burst is stopped on that cycle.
          if (rot_end) begin
            capture_valid <= 1'b1;
            rot_cnt       <= rot_cnt + LEN_W'(1);
            phase_idx     <= '0;
            if (last_rot || stop_req) begin
              state    <= FLUSH;
              phase_en <= '0;
            end else begin
              phase_en <= PHASES'(onehot(0));
            end
          end else if (stop_req) begin
            capture_valid <= 1'b0;
            state         <= FLUSH;
            phase_en      <= '0;
            phase_idx     <= '0;
          end else begin
            capture_valid <= 1'b0;
            phase_idx     <= phase_idx + PIDX_W'(1);
            phase_en      <= next_phase_en;
          end
        end
        FLUSH: begin
          capture_valid <= 1'b0;
          done          <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sampler_phase_ctrl.sv
// Scoreboard bench for sampler_phase_ctrl: each transaction queues its per-cycle
// inputs and the expected outputs, which are compared on the falling clock edge.
module tb_sampler_phase_ctrl;

  localparam int PHASES = 4;
  localparam int LEN_W  = 4;
  localparam int NREQ   = 2;
  localparam int PIDX_W = $clog2(PHASES);
  localparam int OUT_W  = NREQ + 1 + PHASES + PIDX_W + 2;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req;
  logic [LEN_W-1:0]  cfg_len;
  logic              abort;
  logic [NREQ-1:0]   gnt;
  logic              busy;
  logic [PHASES-1:0] phase_en;
  logic [PIDX_W-1:0] phase_idx;
  logic              capture_valid;
  logic              done;

  int total = 0;
  int bad   = 0;
  int model_last = NREQ - 1;

  logic [OUT_W-1:0] exp_q[$];
  logic [NREQ-1:0]  req_q[$];
  logic             ab_q[$];
  logic [LEN_W-1:0] len_q[$];

  sampler_phase_ctrl #(
    .PHASES (PHASES),
    .LEN_W  (LEN_W),
    .NREQ   (NREQ)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req           (req),
    .cfg_len       (cfg_len),
    .abort         (abort),
    .gnt           (gnt),
    .busy          (busy),
    .phase_en      (phase_en),
    .phase_idx     (phase_idx),
    .capture_valid (capture_valid),
    .done          (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [OUT_W-1:0] pack(input logic [NREQ-1:0] g, input logic b,
                                            input logic [PHASES-1:0] pe, input logic [PIDX_W-1:0] pi,
                                            input logic cv, input logic d);
    return {g, b, pe, pi, cv, d};
  endfunction

  function automatic logic [OUT_W-1:0] dut_pack();
    return pack(gnt, busy, phase_en, phase_idx, capture_valid, done);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  task automatic push_step(input logic [OUT_W-1:0] e, input logic [NREQ-1:0] r,
                           input logic a, input logic [LEN_W-1:0] l);
    exp_q.push_back(e);
    req_q.push_back(r);
    ab_q.push_back(a);
    len_q.push_back(l);
  endtask

  // kind 0 = abort pin, kind 1 = granted requester drops; ab_rot < 0 means run to completion.
  task automatic applyStimulus(input logic [NREQ-1:0] req_idle, input logic [NREQ-1:0] req_busy,
                               input int len, input int ab_rot, input int ab_ph,
                               input int kind, input bit noise);
    logic [NREQ-1:0]   g;
    logic [NREQ-1:0]   r_now;
    logic [PHASES-1:0] pe;
    int gi;
    int eff;
    bit cv_flush;
    bit stopped;
    bit hit;
    g  = '0;
    gi = -1;
    for (int i = 1; i <= NREQ; i++) begin
      int c;
      c = (model_last + i) % NREQ;
      if (gi < 0 && req_idle[c]) gi = c;
    end
    g[gi]      = 1'b1;
    model_last = gi;
    eff        = (len == 0) ? 1 : len;
    push_step('0, req_idle, noise, LEN_W'(len));
    r_now    = req_busy;
    stopped  = 1'b0;
    cv_flush = 1'b1;
    for (int rot = 0; rot < eff; rot++) begin
      for (int ph = 0; ph < PHASES; ph++) begin
        if (!stopped) begin
          hit = (rot == ab_rot) && (ph == ab_ph);
          if (hit && kind == 1) r_now = r_now & ~g;
          pe     = '0;
          pe[ph] = 1'b1;
          push_step(pack(g, 1'b1, pe, PIDX_W'(ph), (ph == 0) && (rot > 0), 1'b0),
                    r_now, hit && (kind == 0), LEN_W'($urandom_range(0, 15)));
          if (hit) begin
            stopped  = 1'b1;
            cv_flush = (ph == PHASES - 1);
          end
        end
      end
    end
    push_step(pack(g, 1'b1, '0, '0, cv_flush, 1'b0), r_now, noise, LEN_W'($urandom_range(0, 15)));
    push_step(pack(g, 1'b1, '0, '0, 1'b0, 1'b1), r_now, noise, LEN_W'($urandom_range(0, 15)));
  endtask

  initial begin
    int n;
    bit seen;
    logic [OUT_W-1:0] want;
    logic [NREQ-1:0]  ri;
    logic [NREQ-1:0]  rb;
    int ln;
    n       = 0;
    seen    = 1'b0;
    rst     = 1'b1;
    req     = '0;
    abort   = 1'b0;
    cfg_len = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_state", 32'(dut_pack()), 32'd0);
    rst = 1'b0;

    // Start a burst and hit it with reset in the middle of a rotation.
    @(negedge clk);
    req     = 2'b01;
    cfg_len = 4'd3;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (busy && phase_idx == 2) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("reach_phase2", 32'(seen), 32'd1);
    checkOutput("phase2_en", 32'(phase_en), 32'b0100);
    #3 rst = 1'b1;
    #1 checkOutput("async_reset", 32'(dut_pack()), 32'd0);
    req = '0;
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(2'b11, 2'b11, 1, -1, 0, 0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1, -1, 0, 0, 1'b0);
    applyStimulus(2'b11, 2'b11, 1, -1, 0, 0, 1'b0);
    applyStimulus(2'b01, 2'b01, 2, -1, 0, 0, 1'b0);
    applyStimulus(2'b01, 2'b01, 0, -1, 0, 0, 1'b1);
    applyStimulus(2'b10, 2'b10, 15, -1, 0, 0, 1'b1);
    applyStimulus(2'b01, 2'b01, 3, 1, 1, 0, 1'b1);
    applyStimulus(2'b10, 2'b10, 3, 1, 3, 0, 1'b0);
    applyStimulus(2'b01, 2'b11, 3, 0, 2, 1, 1'b0);
    applyStimulus(2'b10, 2'b10, 1, -1, 0, 0, 1'b0);
    for (int t = 0; t < 6; t++) begin
      ri = NREQ'($urandom_range(1, 3));
      rb = ri | NREQ'($urandom_range(0, 3));
      ln = $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1)
        applyStimulus(ri, rb, ln, $urandom_range(0, (ln == 0) ? 0 : ln - 1),
                      $urandom_range(0, PHASES - 1), $urandom_range(0, 1), 1'($urandom_range(0, 1)));
      else
        applyStimulus(ri, rb, ln, -1, 0, 0, 1'b0);
    end
    push_step('0, '0, 1'b0, '0);
    push_step('0, '0, 1'b1, '0);

    while (exp_q.size() > 0) begin
      @(negedge clk);
      want = exp_q.pop_front();
      checkOutput($sformatf("step%0d", n), 32'(dut_pack()), 32'(want));
      req     = req_q.pop_front();
      abort   = ab_q.pop_front();
      cfg_len = len_q.pop_front();
      n++;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sampler_phase_ctrl.md
Name: sampler_phase_ctrl

Overview:
Controller for the phase-sampled capture datapath, the ring of per-lane hold/load muxes clocked by a rotating phase chain. It shares that datapath between NREQ requesters with round-robin arbitration and a req/gnt handshake. It sequences one-hot phase enables for a programmable number of full rotations, then flushes and reports completion.

Parameters:
PHASES, 4, number of phase enables per rotation (>=2)
LEN_W, 4, width of burst-length (rotation count) field
NREQ, 2, number of requesters (>=2)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous active-high reset
req  in  NREQ  per-requester capture request, level, held until done
cfg_len  in  LEN_W  rotations to run, sampled at grant; 0 treated as 1
abort  in  1  terminate current burst early
gnt  out  NREQ  one-hot grant, held for the whole transaction
busy  out  1  high whenever state != IDLE
phase_en  out  PHASES  one-hot load enable to datapath stages, all-zero outside RUN
phase_idx  out  $clog2(PHASES)  index of the active phase
capture_valid  out  1  one-cycle pulse after each completed rotation
done  out  1  one-cycle pulse at end of transaction

Behaviour:
- Reset (async, immediate): state IDLE; gnt, phase_en, phase_idx, capture_valid, done, busy = 0. Rotation counter 0. RR pointer set so req[0] has highest priority.
- All outputs registered; no combinational path from inputs to outputs.
- States: IDLE -> RUN -> FLUSH -> DONE -> IDLE.
- IDLE: if any req, grant the first set req after the last-granted index (wrap-around). Next cycle: gnt one-hot, state RUN, phase_idx 0, phase_en = 1. Latch len = (cfg_len==0) ? 1 : cfg_len. Update RR pointer to the granted index.
- RUN: phase_idx increments by 1 each cycle, wrapping at PHASES-1 -> 0; phase_en = 1 << phase_idx.
- Rotation end: on the cycle with phase_idx == PHASES-1, increment the rotation count. capture_valid pulses the following cycle. If the count reaches len, the next state is FLUSH; otherwise wrap to phase 0.
- FLUSH: exactly one cycle. phase_en = 0, gnt held. capture_valid may be high here from the final rotation.
- DONE: exactly one cycle. done = 1, gnt held, phase_en = 0. Next state IDLE, where gnt drops.
- Arbitration only occurs in IDLE. Back-to-back transactions are therefore separated by at least one IDLE cycle.
- Timing example, PHASES=4, len=2, req at cycle 0:
  - gnt and phase_en=0001 at cycle 1
  - phase_en=1000 at cycle 4; capture_valid at cycle 5
  - phase_en=1000 at cycle 8; capture_valid and FLUSH at cycle 9
  - done at cycle 10; gnt=0 at cycle 11
- Abort, or the granted req deasserting during RUN: next state FLUSH immediately, with phase_en=0 next cycle. No capture_valid for the partial rotation; done still pulses. Abort in FLUSH, DONE or IDLE is ignored.
- Simultaneous abort and rotation completion: capture_valid still pulses, then FLUSH (same as normal end).
- Non-granted req changes while busy are ignored; they are evaluated in the next IDLE.
- cfg_len changes after grant have no effect on the current burst.

Decomposition:
- Package sampler_ctrl_pkg: state enum (IDLE, RUN, FLUSH, DONE), default PHASES/LEN_W/NREQ constants, helper function onehot(idx).
- One sub-module, rr_arbiter: NREQ-wide round-robin with registered last-grant pointer and an enable input (asserted only in IDLE).
- The main block holds the FSM, phase counter and rotation counter.

Test Plan:
- Reset mid-RUN (assert rst at phase_idx=2) -> all outputs 0 immediately and asynchronously. After release, req[1] alone is granted one cycle after it is seen.
- req=01, cfg_len=2, PHASES=4 -> gnt=01 at c1; phase_en 0001,0010,0100,1000 twice; capture_valid at c5 and c9; done at c10; gnt=0 at c11.
- req=11 held continuously with cfg_len=1 -> grants alternate 01, 10, 01. Each transaction spans RUN 4 + FLUSH 1 + DONE 1 cycles, followed by at least 1 IDLE cycle.
- cfg_len=0 -> exactly one rotation and one capture_valid; cfg_len=15 -> 15 capture_valid pulses, then done.
- abort at the RUN cycle with phase_idx=1 of rotation 1 -> phase_en=0 next cycle, no further capture_valid, done 2 cycles after the abort. Repeat with abort coinciding with phase_idx=3 -> capture_valid still pulses.
- Granted req dropped mid-RUN -> behaves as abort. A new req on the other requester during busy is granted only after done plus one IDLE cycle.
